// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants: default widths, bubble instruction, register-field positions
package riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  localparam int REG_AW  = 5;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry ready/valid skid buffer with flush; s_tready is registered
module pipe_skid_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         s_tvalid_i,
  output logic         s_tready_o,
  input  logic [W-1:0] s_tdata_i,
  output logic         m_tvalid_o,
  input  logic         m_tready_i,
  output logic [W-1:0] m_tdata_o,
  output logic [1:0]   count_o
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         handoff;

  assign accept  = s_tvalid_i && !skid_valid_q;
  assign handoff = main_valid_q && m_tready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    // Flush only drops valids so the main payload (and thus the last PC) is retained.
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (handoff && skid_valid_q) begin
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (handoff || !main_valid_q) begin
      main_valid_d = accept;
      if (accept) main_d = s_tdata_i;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = s_tdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign s_tready_o = !skid_valid_q;
  assign m_tvalid_o = main_valid_q;
  assign m_tdata_o  = main_q;
  assign count_o    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/if_id_pipe.sv
// rtl/if_id_pipe.sv - IF/ID pipeline register: skid-buffered beat hold, bubble insertion, register-field decode
module if_id_pipe
  import riscv_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              ILEN      = ILEN_DEF,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(NOP_INSTR_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [ILEN-1:0] if_instr,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instr,
  output reg_addr_t       rs1_raddr,
  output reg_addr_t       rs2_raddr,
  output reg_addr_t       rd_waddr_id,
  output logic [1:0]      occupancy
);

  localparam int W = XLEN + ILEN;

  logic [W-1:0]    beat_in;
  logic [W-1:0]    beat_out;
  logic [ILEN-1:0] held_instr;

  assign beat_in = {if_pc, if_instr};

  pipe_skid_buf #(.W(W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .s_tvalid_i (if_valid),
    .s_tready_o (if_ready),
    .s_tdata_i  (beat_in),
    .m_tvalid_o (id_valid),
    .m_tready_i (id_ready),
    .m_tdata_o  (beat_out),
    .count_o    (occupancy)
  );

  assign id_pc      = beat_out[W-1:ILEN];
  assign held_instr = beat_out[ILEN-1:0];

  // Decode from the bubbled instruction so idle cycles present x0 addresses.
  assign id_instr    = id_valid ? held_instr : NOP_INSTR;
  assign rs1_raddr   = id_instr[RS1_LSB +: REG_AW];
  assign rs2_raddr   = id_instr[RS2_LSB +: REG_AW];
  assign rd_waddr_id = id_instr[RD_LSB +: REG_AW];

endmodule

// File: tb/tb_if_id_pipe.sv
// tb/tb_if_id_pipe.sv - self-checking bench for if_id_pipe with a FIFO-level reference model
module tb_if_id_pipe;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_pc = '0;
  logic [31:0] if_instr = '0;
  logic        flush = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [4:0]  rs1_raddr;
  logic [4:0]  rs2_raddr;
  logic [4:0]  rd_waddr_id;
  logic [1:0]  occupancy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  beat_t       q[$];
  logic [31:0] last_pc = '0;

  always #5 clk = ~clk;

  if_id_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .rs1_raddr   (rs1_raddr),
    .rs2_raddr   (rs2_raddr),
    .rd_waddr_id (rd_waddr_id),
    .occupancy   (occupancy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: the stage is a FIFO of at most two beats; acceptance only below two.
  task automatic model_step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                            input logic rdy, input logic fl);
    bit acc;
    bit ho;
    beat_t b;
    acc = v && (q.size() < 2);
    ho  = (q.size() > 0) && rdy;
    b.pc = pc;
    b.instr = ins;
    if (fl) q.delete();
    else begin
      if (ho) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    if (q.size() > 0) last_pc = q[0].pc;
  endtask

  task automatic model_reset();
    q.delete();
    last_pc = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] e_instr;
      e_instr = (q.size() > 0) ? q[0].instr : NOP;
      chk("id_valid", 64'(id_valid), 64'(q.size() > 0));
      chk("id_pc", 64'(id_pc), 64'(last_pc));
      chk("id_instr", 64'(id_instr), 64'(e_instr));
      chk("rs1", 64'(rs1_raddr), 64'(e_instr[19:15]));
      chk("rs2", 64'(rs2_raddr), 64'(e_instr[24:20]));
      chk("rd", 64'(rd_waddr_id), 64'(e_instr[11:7]));
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("if_ready", 64'(if_ready), 64'(q.size() < 2));
    end
  end

  // Inputs are applied just after a falling edge and held through the next rising edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
    id_ready = rdy;
    flush    = fl;
    model_step(v, pc, ins, rdy, fl);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'hdead_beef, 32'hffff_ffff, rdy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd1);
    chk("rst_id_pc", 64'(id_pc), 64'd0);
    chk("rst_id_instr", 64'(id_instr), 64'(NOP));
    chk("rst_occ", 64'(occupancy), 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    step(1'b1, 32'h100, 32'h0020_8033, 1'b1, 1'b0);
    chk("first_valid", 64'(id_valid), 64'd1);
    chk("first_pc", 64'(id_pc), 64'h100);
    chk("first_rs1", 64'(rs1_raddr), 64'd1);
    chk("first_rs2", 64'(rs2_raddr), 64'd2);
    chk("first_rd", 64'(rd_waddr_id), 64'd0);
    chk("first_occ", 64'(occupancy), 64'd1);
    idle(1'b1);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'(4 * i), 32'h0000_0033 | 32'(i << 7), 1'b1, 1'b0);
      chk("stream_pc", 64'(id_pc), 64'(4 * i));
      chk("stream_if_ready", 64'(if_ready), 64'd1);
    end
    idle(1'b1);

    step(1'b1, 32'h10, 32'h0031_0093, 1'b0, 1'b0);
    step(1'b1, 32'h14, 32'h0041_8113, 1'b0, 1'b0);
    chk("stall_occ", 64'(occupancy), 64'd2);
    chk("stall_if_ready", 64'(if_ready), 64'd0);
    chk("stall_pc", 64'(id_pc), 64'h10);
    step(1'b1, 32'h18, 32'h0, 1'b0, 1'b0);
    chk("stall_pc_hold", 64'(id_pc), 64'h10);
    chk("stall_instr_hold", 64'(id_instr), 64'h0031_0093);
    idle(1'b1);
    chk("drain_pc", 64'(id_pc), 64'h14);
    chk("drain_if_ready", 64'(if_ready), 64'd1);
    idle(1'b1);
    chk("drain_empty", 64'(occupancy), 64'd0);

    step(1'b1, 32'h40, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h44, 32'h2, 1'b0, 1'b0);
    step(1'b1, 32'h20, 32'h0050_0293, 1'b0, 1'b1);
    chk("flush_valid", 64'(id_valid), 64'd0);
    chk("flush_instr", 64'(id_instr), 64'(NOP));
    chk("flush_occ", 64'(occupancy), 64'd0);
    idle(1'b1);
    chk("flush_no_0x20", 64'(id_valid), 64'd0);

    step(1'b1, 32'h50, 32'h3, 1'b0, 1'b0);
    step(1'b1, 32'h54, 32'h4, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("flush_ho_occ", 64'(occupancy), 64'd0);
    chk("flush_ho_valid", 64'(id_valid), 64'd0);

    step(1'b1, 32'h60, 32'h0062_8333, 1'b0, 1'b0);
    step(1'b1, 32'h64, 32'h5, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", 64'(id_valid), 64'd0);
    chk("async_rst_occ", 64'(occupancy), 64'd0);
    chk("async_rst_if_ready", 64'(if_ready), 64'd1);
    chk("async_rst_pc", 64'(id_pc), 64'd0);
    chk("async_rst_instr", 64'(id_instr), 64'(NOP));
    if_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 32'h200, 32'h0000_0033, 1'b1, 1'b0);
    chk("post_rst_pc", 64'(id_pc), 64'h200);
    chk("post_rst_valid", 64'(id_valid), 64'd1);

    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 9) < 7), $urandom, $urandom,
           1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
    end
    idle(1'b1);
    idle(1'b1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC width.
REQ-002 SHALL have parameter ILEN, default 32, meaning instruction width (>=25 so register fields exist).
REQ-003 SHALL have parameter NOP_INSTR, default 32'h00000013, meaning bubble instruction (addi x0,x0,0).
REQ-004 SHALL have port clk  input  1  the only clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port if_valid  input  1  IF offers a beat.
REQ-007 SHALL have port if_ready  output  1  stage can accept a beat.
REQ-008 SHALL have port if_pc  input  XLEN  PC of offered beat.
REQ-009 SHALL have port if_instr  input  ILEN  instruction of offered beat.
REQ-010 SHALL have port flush  input  1  discard all held and incoming beats.
REQ-011 SHALL have port id_valid  output  1  ID beat valid.
REQ-012 SHALL have port id_ready  input  1  ID consumes the beat.
REQ-013 SHALL have port id_pc  output  XLEN  PC of ID beat.
REQ-014 SHALL have port id_instr  output  ILEN  instruction of ID beat.
REQ-015 SHALL have ports rs1_raddr, rs2_raddr, rd_waddr_id  output  5 each  id_instr[19:15], [24:20], [11:7].
REQ-016 SHALL have port occupancy  output  2  number of held beats, 0..2.

Function
REQ-017 SHALL hold up to two beats: main entry (drives id_*) and skid entry; beat order preserved.
REQ-018 SHALL accept a beat when if_valid && if_ready; SHALL hand off a beat when id_valid && id_ready.
REQ-019 SHALL drive if_ready = !skid_valid, from a register only (no combinational path from id_ready).
REQ-020 SHALL present an accepted beat on id_* the cycle after acceptance when main is empty or is being handed off (latency 1).
REQ-021 SHALL sustain one beat per cycle while id_ready=1.
REQ-022 SHALL load an accepted beat into skid when main is full and not handed off; if_ready is then 0 the next cycle.
REQ-023 SHALL, on handoff with skid full, move skid to main and clear skid in that cycle; no input is accepted in that cycle.
REQ-024 SHALL drive id_instr = NOP_INSTR whenever id_valid=0; id_pc holds its last value.
REQ-025 SHALL derive register-address outputs from id_instr, so they read 0 while id_valid=0.
REQ-026 SHALL, on flush=1, clear main and skid at the next edge; a beat accepted or handed off in the flush cycle is discarded or completed respectively, and no beat survives.
REQ-027 SHALL give flush priority over every simultaneous accept/handoff/skid move.
REQ-028 SHALL drive occupancy = main_valid + skid_valid; skid_valid=1 implies main_valid=1.
REQ-029 SHALL leave id_* unchanged while id_valid=1 and id_ready=0 (stall stability).

Reset
REQ-030 SHALL, with rst_n=0, asynchronously force main_valid=0, skid_valid=0, id_valid=0, if_ready=1, id_pc=0, id_instr=NOP_INSTR, occupancy=0.
REQ-031 SHALL discard any held beats if reset is asserted mid-operation; first acceptance is possible on the first edge after rst_n deasserts.

Structure
REQ-032 SHALL take XLEN/ILEN defaults, NOP_INSTR and the register-field bit positions from the shared core package (riscv_pkg).
REQ-033 SHALL have one sub-module, pipe_skid_buf, a generic parametrised 2-entry ready/valid skid buffer of width XLEN+ILEN; field decode and NOP insertion stay in if_id_pipe.

Verification
REQ-034 SHALL cover: reset, then if_valid=1, pc=0x100, instr=0x00208033, id_ready=1 -> next cycle id_valid=1, id_pc=0x100, rs1=1, rs2=2, rd=0, occupancy=1.
REQ-035 SHALL cover: stream pc 0x0,0x4,0x8 back-to-back with id_ready=1 -> ID sees 0x0,0x4,0x8 on consecutive cycles, if_ready stays 1.
REQ-036 SHALL cover: id_ready=0 with two beats 0x10,0x14 offered -> occupancy=2, if_ready=0, id_pc stays 0x10; id_ready=1 -> 0x10 then 0x14 in order, if_ready=1 one cycle after skid drains.
REQ-037 SHALL cover: occupancy=2 and flush=1 with if_valid=1 pc=0x20 -> next cycle id_valid=0, id_instr=0x00000013, occupancy=0, 0x20 never appears.
REQ-038 SHALL cover: rst_n pulsed low mid-stall with occupancy=2 -> outputs take reset values immediately, without a clock edge.
REQ-039 SHALL cover: flush and handoff in the same cycle with skid full -> skid beat dropped, occupancy=0 next cycle.
